// File: rtl/bananachine_pkg.sv
// Shared encodings for the Bananachine control path: FSM states, opcode and
// extension fields, ALU control words, condition codes and PSR bit positions.
package bananachine_pkg;

  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, MEM, WB} state_t;

  // Primary opcodes, IR[15:12]
  localparam logic [3:0] OP_REG     = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_ADDUI   = 4'b0110;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // Extension codes, IR[7:4]
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;

  // ALU control words: [5:4] category, [3:0] function
  localparam logic [1:0] CAT_ALU  = 2'b00;
  localparam logic [5:0] ALU_LSH  = 6'b100101;
  localparam logic [5:0] ALU_LSHI = 6'b100000;
  localparam logic [5:0] ALU_LUI  = 6'b111111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  // Condition codes, carried in the rd field
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  // Everything the EXEC state drives, decoded from IR ahead of time
  typedef struct packed {
    logic [5:0] alu_cont;
    logic       imm_sel;
    logic       sign_ext;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       psr_we;
    logic [1:0] pc_src;
    logic       mem_op;
    logic       store;
    logic       illegal;
  } exec_ctrl_t;

  function automatic logic is_imm_op(input logic [3:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI,
                      OP_SUBI, OP_CMPI, OP_MOVI};
  endfunction

  // Logical immediates take a zero-extended operand
  function automatic logic is_logic_imm(input logic [3:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

endpackage

// File: rtl/bcond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the PSR
// flag word to a taken decision. Shared by Bcond and Jcond.
module bcond_eval
  import bananachine_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] psr_flags,
  output logic             taken
);

  logic c, l, f, z, n;
  logic unused_flags;

  assign c = psr_flags[PSR_C];
  assign l = psr_flags[PSR_L];
  assign f = psr_flags[PSR_F];
  assign z = psr_flags[PSR_Z];
  assign n = psr_flags[PSR_N];
  assign unused_flags = ^{psr_flags[WIDTH-1:8], psr_flags[4:3], psr_flags[1]};

  // NOTE: every always_comb output gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      CC_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_decoder.sv
// Multi-cycle control FSM and instruction decoder for the Bananachine core.
// Define CTRL_JUMP_EN to decode Jcond/JAL; otherwise they trap as illegal NOPs.
module ctrl_decoder
  import bananachine_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         instr,
  input  logic                     mem_ack,
  input  logic [WIDTH-1:0]         psr_flags,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     addr_sel,
  output logic                     ir_load,
  output logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic                     imm_sel,
  output logic                     sign_ext,
  output logic                     rf_we,
  output logic [1:0]               wb_sel,
  output logic                     psr_we,
  output logic                     pc_en,
  output logic [1:0]               pc_src,
  output logic                     illegal
);

  state_t           state, state_next;
  logic [WIDTH-1:0] ir;
  logic [3:0]       op, rd, ext;
  logic             taken;
  exec_ctrl_t       dec;
  logic             unused_ir;

  assign op        = ir[15:12];
  assign rd        = ir[11:8];
  assign ext       = ir[7:4];
  assign unused_ir = ^ir[3:0];

  bcond_eval #(.WIDTH(WIDTH)) u_bcond (
    .cond      (rd),
    .psr_flags (psr_flags),
    .taken     (taken)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (ir_load) ir <= instr;
    end
  end

  // Instruction decode: what EXEC would drive for the instruction in IR
  always_comb begin
    dec = '0;
    case (op)
      OP_REG: begin
        dec.alu_cont = {CAT_ALU, ext};
        dec.rf_we    = (ext != EXT_CMP);
        dec.psr_we   = ext inside {EXT_ADD, EXT_SUB, EXT_CMP};
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        dec.alu_cont = {CAT_ALU, op};
        dec.imm_sel  = 1'b1;
        dec.sign_ext = !is_logic_imm(op);
        dec.rf_we    = (op != OP_CMPI);
        dec.psr_we   = op inside {OP_ADDI, OP_SUBI, OP_CMPI};
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH) begin
          dec.alu_cont = ALU_LSH;
          dec.rf_we    = 1'b1;
        end else if (ext[3:1] == 3'b000) begin
          // LSHI: the low ext bit is part of the shift immediate
          dec.alu_cont = ALU_LSHI;
          dec.imm_sel  = 1'b1;
          dec.sign_ext = 1'b1;
          dec.rf_we    = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        dec.alu_cont = ALU_LUI;
        dec.imm_sel  = 1'b1;
        dec.rf_we    = 1'b1;
      end
      OP_BCOND: dec.pc_src = taken ? PC_DISP : PC_INC;
      OP_SPECIAL: begin
        case (ext)
          EXT_LOAD: dec.mem_op = 1'b1;
          EXT_STOR: begin
            dec.mem_op = 1'b1;
            dec.store  = 1'b1;
          end
`ifdef CTRL_JUMP_EN
          EXT_JCOND: dec.pc_src = taken ? PC_REG : PC_INC;
          EXT_JAL: begin
            dec.rf_we  = 1'b1;
            dec.wb_sel = WB_PC;
            dec.pc_src = PC_REG;
          end
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // FSM next state and outputs
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    alu_cont   = '0;
    imm_sel    = 1'b0;
    sign_ext   = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    psr_we     = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_INC;
    illegal    = 1'b0;
    case (state)
      INIT: state_next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        if (dec.mem_op) begin
          state_next = MEM;
        end else begin
          alu_cont   = dec.alu_cont;
          imm_sel    = dec.imm_sel;
          sign_ext   = dec.sign_ext;
          rf_we      = dec.rf_we;
          wb_sel     = dec.wb_sel;
          psr_we     = dec.psr_we;
          pc_src     = dec.pc_src;
          illegal    = dec.illegal;
          pc_en      = 1'b1;
          state_next = FETCH;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = dec.store;
        if (mem_ack) begin
          if (dec.store) begin
            pc_en      = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        wb_sel     = WB_MEM;
        pc_en      = 1'b1;
        state_next = FETCH;
      end
      default: state_next = INIT;
    endcase
  end

endmodule

// File: tb/tb_ctrl_decoder.sv
// Self-checking bench for ctrl_decoder: a table-driven instruction model
// predicts every output on every cycle, plus literal checks on known encodings.
module tb_ctrl_decoder;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic [5:0] alu_cont;
    logic       imm_sel;
    logic       sign_ext;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       psr_we;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [7:0] val;
    logic [7:0] mask;
    int         alu;   // -1: {00,ext}, -2: {00,op}, else literal code
    bit         imm;
    bit         sext;
    bit         wr;
    bit         flg;
    int         cls;
  } ent_t;

  localparam int CL_ALU = 0, CL_BR = 1, CL_JC = 2, CL_JAL = 3, CL_LD = 4, CL_ST = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] psr_flags = '0;
  logic        mem_req, mem_we, addr_sel, ir_load, imm_sel, sign_ext, rf_we;
  logic        psr_we, pc_en, illegal;
  logic [5:0]  alu_cont;
  logic [1:0]  wb_sel, pc_src;

  out_t  dut_o, exp_o;
  bit    exp_valid = 1'b0;
  string exp_tag = "";
  out_t  trace[$];
  ent_t  tbl[$];
  int    vectors = 0;
  int    miscompares = 0;

  ctrl_decoder #(.WIDTH(16), .ALU_CONT_BITS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ack   (mem_ack),
    .psr_flags (psr_flags),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_load   (ir_load),
    .alu_cont  (alu_cont),
    .imm_sel   (imm_sel),
    .sign_ext  (sign_ext),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .psr_we    (psr_we),
    .pc_en     (pc_en),
    .pc_src    (pc_src),
    .illegal   (illegal)
  );

  assign dut_o = {mem_req, mem_we, addr_sel, ir_load, alu_cont, imm_sel, sign_ext,
                  rf_we, wb_sel, psr_we, pc_en, pc_src, illegal};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (exp_valid) begin
      trace.push_back(dut_o);
      check({"cycle_", exp_tag}, 32'(dut_o), 32'(exp_o));
    end
  end

  task automatic add_ent(input logic [7:0] val, input logic [7:0] mask, input int alu,
                         input bit imm, input bit sext, input bit wr, input bit flg,
                         input int cls);
    ent_t e;
    e.val = val; e.mask = mask; e.alu = alu; e.imm = imm;
    e.sext = sext; e.wr = wr; e.flg = flg; e.cls = cls;
    tbl.push_back(e);
  endtask

  // Instruction table keyed on {op, ext}; first match wins
  task automatic build_table();
    add_ent(8'h05, 8'hFF, -1, 0, 0, 1, 1, CL_ALU);  // ADD
    add_ent(8'h09, 8'hFF, -1, 0, 0, 1, 1, CL_ALU);  // SUB
    add_ent(8'h0B, 8'hFF, -1, 0, 0, 0, 1, CL_ALU);  // CMP
    add_ent(8'h00, 8'hF0, -1, 0, 0, 1, 0, CL_ALU);  // other register ops
    add_ent(8'h10, 8'hF0, -2, 1, 0, 1, 0, CL_ALU);  // ANDI
    add_ent(8'h20, 8'hF0, -2, 1, 0, 1, 0, CL_ALU);  // ORI
    add_ent(8'h30, 8'hF0, -2, 1, 0, 1, 0, CL_ALU);  // XORI
    add_ent(8'h50, 8'hF0, -2, 1, 1, 1, 1, CL_ALU);  // ADDI
    add_ent(8'h60, 8'hF0, -2, 1, 1, 1, 0, CL_ALU);  // ADDUI
    add_ent(8'h90, 8'hF0, -2, 1, 1, 1, 1, CL_ALU);  // SUBI
    add_ent(8'hB0, 8'hF0, -2, 1, 1, 0, 1, CL_ALU);  // CMPI
    add_ent(8'hD0, 8'hF0, -2, 1, 1, 1, 0, CL_ALU);  // MOVI
    add_ent(8'h84, 8'hFF, 37, 0, 0, 1, 0, CL_ALU);  // LSH  100101
    add_ent(8'h80, 8'hFE, 32, 1, 1, 1, 0, CL_ALU);  // LSHI 100000
    add_ent(8'hF0, 8'hF0, 63, 1, 0, 1, 0, CL_ALU);  // LUI  111111
    add_ent(8'hC0, 8'hF0, 0, 0, 0, 0, 0, CL_BR);    // Bcond
    add_ent(8'h40, 8'hFF, 0, 0, 0, 0, 0, CL_LD);    // LOAD
    add_ent(8'h44, 8'hFF, 0, 0, 0, 0, 0, CL_ST);    // STOR
`ifdef CTRL_JUMP_EN
    add_ent(8'h4C, 8'hFF, 0, 0, 0, 0, 0, CL_JC);    // Jcond
    add_ent(8'h48, 8'hFF, 0, 0, 0, 0, 0, CL_JAL);   // JAL
`endif
  endtask

  // Expected EXEC-cycle outputs and the instruction class
  function automatic void model_exec(input logic [15:0] ins, input logic [15:0] fl,
                                     output out_t o, output int kind);
    logic [7:0] key, base;
    logic [3:0] cond;
    bit         tk;
    int         hit;
    key  = {ins[15:12], ins[7:4]};
    cond = ins[11:8];
    o    = '0;
    kind = CL_ALU;
    hit  = -1;
    for (int i = 0; i < tbl.size(); i++)
      if (hit < 0 && (key & tbl[i].mask) == tbl[i].val) hit = i;
    if (hit < 0) begin
      o.illegal = 1'b1;
      o.pc_en   = 1'b1;
      return;
    end
    kind = tbl[hit].cls;
    if (kind == CL_LD || kind == CL_ST) return;
    o.pc_en = 1'b1;
    if (tbl[hit].alu == -1)      o.alu_cont = {2'b00, ins[7:4]};
    else if (tbl[hit].alu == -2) o.alu_cont = {2'b00, ins[15:12]};
    else                         o.alu_cont = 6'(tbl[hit].alu);
    o.imm_sel  = tbl[hit].imm;
    o.sign_ext = tbl[hit].sext;
    o.rf_we    = tbl[hit].wr;
    o.psr_we   = tbl[hit].flg;
    // Condition pairs: odd code is the complement of the even one below it
    base = {1'b1, !fl[7] && !fl[6], !fl[2] && !fl[6], fl[5], fl[7], fl[2], fl[0], fl[6]};
    tk   = base[cond[3:1]] ^ cond[0];
    if (kind == CL_BR) o.pc_src = tk ? 2'b01 : 2'b00;
    if (kind == CL_JC) o.pc_src = tk ? 2'b10 : 2'b00;
    if (kind == CL_JAL) begin
      o.rf_we  = 1'b1;
      o.wb_sel = 2'b10;
      o.pc_src = 2'b10;
    end
  endfunction

  task automatic step(input logic ack, input logic [15:0] ins, input logic [15:0] fl,
                      input out_t e, input string tag);
    mem_ack   = ack;
    instr     = ins;
    psr_flags = fl;
    exp_o     = e;
    exp_tag   = tag;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Whole instruction from FETCH; nf/nm are fetch/memory wait cycles
  task automatic run_instr(input logic [15:0] ins, input int nf, input int nm,
                           input logic [15:0] fl);
    out_t e;
    int   kind;
    trace.delete();
    for (int k = 0; k <= nf; k++) begin
      e = '0;
      e.mem_req = 1'b1;
      e.ir_load = (k == nf);
      step(k == nf, (k == nf) ? ins : 16'($urandom), 16'($urandom), e, "fetch");
    end
    step(1'($urandom), 16'($urandom), 16'($urandom), '0, "decode");
    model_exec(ins, fl, e, kind);
    step(1'($urandom), 16'($urandom), fl, e, "exec");
    if (kind == CL_LD || kind == CL_ST) begin
      for (int k = 0; k <= nm; k++) begin
        e = '0;
        e.mem_req  = 1'b1;
        e.addr_sel = 1'b1;
        e.mem_we   = (kind == CL_ST);
        e.pc_en    = (kind == CL_ST) && (k == nm);
        step(k == nm, 16'($urandom), 16'($urandom), e, "mem");
      end
      if (kind == CL_LD) begin
        e = '0;
        e.rf_we  = 1'b1;
        e.wb_sel = 2'b01;
        e.pc_en  = 1'b1;
        step(1'($urandom), 16'($urandom), 16'($urandom), e, "wb");
      end
    end
  endtask

  initial begin
    out_t       e;
    int         kind;
    ent_t       pick;
    logic [7:0] key;
    logic [15:0] ins;

    build_table();
    @(posedge clk);
    #1;
    step(1'b1, 16'h0152, 16'hFFFF, '0, "reset");
    step(1'b1, 16'h0152, 16'hFFFF, '0, "reset");
    reset = 1'b1;
    step(1'b1, 16'h0152, 16'h0000, '0, "init");

    run_instr(16'h0152, 0, 0, 16'h0000);
    check("add_alu_cont", trace[2].alu_cont, 6'b000101);
    check("add_imm_sel", trace[2].imm_sel, 0);
    check("add_rf_we", trace[2].rf_we, 1);
    check("add_psr_we", trace[2].psr_we, 1);

    run_instr(16'h53FF, 0, 0, 16'h0000);
    check("addi_imm_sel", trace[0].mem_req & ~trace[1].mem_req & trace[2].imm_sel, 1);
    check("addi_sign_ext", trace[2].sign_ext, 1);
    run_instr(16'h13FF, 1, 0, 16'h0000);
    check("andi_sign_ext", trace[3].sign_ext, 0);
    check("andi_imm_sel", trace[3].imm_sel, 1);

    run_instr(16'hC0FE, 0, 0, 16'h0040);
    check("beq_taken_src", trace[2].pc_src, 2'b01);
    check("beq_taken_en", trace[2].pc_en, 1);
    run_instr(16'hC0FE, 0, 0, 16'h0000);
    check("beq_not_taken_src", trace[2].pc_src, 2'b00);

    run_instr(16'h4201, 0, 2, 16'h0000);
    check("load_mem_addr_sel", trace[4].addr_sel, 1);
    check("load_mem_we", trace[4].mem_we, 0);
    check("load_mem_hold", trace[5].mem_req, 1);
    check("load_wb_rf_we", trace[6].rf_we, 1);
    check("load_wb_sel", trace[6].wb_sel, 2'b01);

    run_instr(16'h4783, 0, 0, 16'h0000);
`ifdef CTRL_JUMP_EN
    check("jal_rf_we", trace[2].rf_we, 1);
    check("jal_wb_sel", trace[2].wb_sel, 2'b10);
    check("jal_pc_src", trace[2].pc_src, 2'b10);
`else
    check("jal_illegal", trace[2].illegal, 1);
    check("jal_rf_we", trace[2].rf_we, 0);
    check("jal_pc_src", trace[2].pc_src, 2'b00);
`endif

    // STOR interrupted by reset while waiting in MEM
    trace.delete();
    e = '0; e.mem_req = 1'b1; e.ir_load = 1'b1;
    step(1'b1, 16'h4241, 16'h0000, e, "stor_fetch");
    step(1'b0, 16'h0000, 16'h0000, '0, "stor_decode");
    step(1'b0, 16'h0000, 16'h0000, '0, "stor_exec");
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
    step(1'b0, 16'h0000, 16'h0000, e, "stor_mem");
    mem_ack = 1'b1;
    exp_o   = '0;
    exp_tag = "reset_mem";
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mem_we", trace[trace.size()-1].mem_we, 0);
    check("reset_mem_req", trace[trace.size()-1].mem_req, 0);
    step(1'b1, 16'h0000, 16'h0000, '0, "reset_hold");
    reset = 1'b1;
    step(1'b1, 16'h0000, 16'h0000, '0, "init_after_reset");
    run_instr(16'h0152, 0, 0, 16'h0000);
    check("post_reset_fetch_req", trace[0].mem_req, 1);
    check("post_reset_fetch_addr", trace[0].addr_sel, 0);

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        ins = 16'($urandom);
      end else begin
        pick = tbl[$urandom_range(0, tbl.size() - 1)];
        key  = (pick.val & pick.mask) | (8'($urandom) & ~pick.mask);
        ins  = {key[7:4], 4'($urandom), key[3:0], 4'($urandom)};
      end
      model_exec(ins, 16'h0000, e, kind);
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 16'($urandom));
    end

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_decoder.md
# ctrl_decoder

Multi-cycle control unit and instruction decoder for the 16-bit Bananachine core. Fetches an instruction over the memory handshake, decodes the opcode/extension fields and drives the 6-bit `alu_cont` word, register-file write, immediate select and PC controls. It also consumes the 16-bit `psr_flags` word the ALU produces, to resolve Bcond/Jcond. It is the producer of the ALU control encoding and the consumer of its flags, and sits between instruction memory, the datapath muxes and the ALU/register-file block.

## Interface
- `WIDTH`, 16: datapath/instruction width.
- `ALU_CONT_BITS`, 6: ALU control width; `[5:4]` is the category (00 ALU, 10 shift, 11 LUI/special), `[3:0]` is the function code.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `instr` input WIDTH: memory read data, captured into IR.
- `mem_ack` input 1: memory completes the current request this cycle.
- `psr_flags` input WIDTH: flag word; bit 0 C, bit 2 L, bit 5 F, bit 6 Z, bit 7 N.
- `mem_req` output 1: memory request.
- `mem_we` output 1: store qualifier, valid with `mem_req`.
- `addr_sel` output 1: 0 = PC, 1 = Rsrc register as address.
- `ir_load` output 1: IR capture strobe.
- `alu_cont` output ALU_CONT_BITS: ALU operation.
- `imm_sel` output 1: ALU b operand = extended immediate.
- `sign_ext` output 1: immediate sign-extended (0 = zero-extended).
- `rf_we` output 1: register write to `IR[11:8]`.
- `wb_sel` output 2: 00 ALU, 01 memory data, 10 PC+1.
- `psr_we` output 1: latch flags.
- `pc_en` output 1: PC update.
- `pc_src` output 2: 00 PC+1, 01 PC+sext(disp8), 10 Rtarget.
- `illegal` output 1: one-cycle pulse on an undefined encoding.

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB. Async reset to INIT; IR clears to 0.
- INIT: all outputs 0; the next state is FETCH.
- FETCH: `mem_req=1`, `addr_sel=0`. While `mem_ack=0`, stay in FETCH. On `mem_ack`, `ir_load=1`, go to DECODE.
- DECODE: outputs 0; fields latch from IR (op `[15:12]`, rd `[11:8]`, ext `[7:4]`, rs `[3:0]`, imm `[7:0]`). Next state is EXEC.
- EXEC, by class:
  - Register ops (op 0000): `alu_cont={00,ext}`, `imm_sel=0`.
  - Immediate ops (op ∈ {0001,0010,0011,0101,0110,1001,1011,1101}): `alu_cont={00,op}`, `imm_sel=1`. `sign_ext=1` except ANDI/ORI/XORI.
  - `rf_we=1` for all ALU/immediate ops except CMP/CMPI.
  - `psr_we=1` for ADD(I), SUB(I), CMP(I).
  - Shifts (op 1000): LSH (ext 0100) gives `alu_cont=100101`. LSHI (ext 000x) gives `alu_cont=100000`, `imm_sel=1`, `sign_ext=1`.
  - LUI (op 1111): `alu_cont=111111`, `imm_sel=1`, `rf_we=1`.
  - Bcond (op 1100): `pc_src=01` if taken, else `00`. No register write.
  - Special (op 0100):
    - LOAD (ext 0000) goes to MEM.
    - STOR (ext 0100) goes to MEM.
    - Jcond (ext 1100): `pc_src=10` if taken.
    - JAL (ext 1000): `rf_we=1`, `wb_sel=10`, `pc_src=10`.
  - `pc_en=1` in EXEC for all non-memory instructions; the next state is FETCH.
- MEM: `mem_req=1`, `addr_sel=1`, `mem_we=1` for STOR. Stay in MEM until `mem_ack`. Then LOAD goes to WB; STOR asserts `pc_en` with `pc_src=00` and goes to FETCH.
- WB (LOAD only): `rf_we=1`, `wb_sel=01`, `pc_en=1`. Next state is FETCH.
- Conditions (code in rd field):
  - EQ 0000 Z; NE 0001 !Z.
  - CS 0010 C; CC 0011 !C.
  - HI 0100 L; LS 0101 !L.
  - GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F.
  - LO 1010 !L&!Z; HS 1011 L|Z.
  - LT 1100 !N&!Z; GE 1101 N|Z.
  - UC 1110 always; 1111 never.
- Undefined encoding: `illegal=1` in EXEC, treated as NOP (`pc_en=1`, `pc_src=00`, no writes).

## Timing
- All outputs are combinational from state plus IR. Every output is 0 in INIT and DECODE, except as listed above.
- Zero-wait memory (ack in the same cycle as req):
  - ALU, branch and jump instructions take 3 cycles (FETCH, DECODE, EXEC).
  - STOR takes 4 cycles.
  - LOAD takes 5 cycles.
  - Each memory wait cycle adds exactly 1.
- Flags are sampled in EXEC. A CMP immediately followed by a Bcond sees the updated PSR, because the ALU latches flags at the end of the CMP's EXEC.
- `mem_ack` outside FETCH/MEM is ignored.
- Reset asserted mid-instruction: INIT immediately (asynchronous). No `rf_we`/`mem_we` in the reset cycle, and any in-flight access is abandoned.

## Configuration
- `CTRL_JUMP_EN` defined: Jcond and JAL are decoded as above.
- Not defined: op 0100 with ext 1100/1000 is illegal. `illegal` pulses, the instruction executes as a NOP, and `pc_src` never equals 10.

## Structure
- `bananachine_pkg` holds:
  - the state enum;
  - opcode/extension constants;
  - `alu_cont` encodings (ALU 00xxxx, LSH 100101, LSHI 100000, LUI 111111);
  - condition-code constants;
  - PSR bit indices (C=0, L=2, F=5, Z=6, N=7).
- Sub-module `bcond_eval`: combinational, takes a 4-bit cond and `psr_flags`, outputs `taken`. It is shared by Bcond and Jcond.

## Test plan
- `instr=0x0152` (ADD r1,r2) with ack same cycle. Expect `alu_cont=000101`, `imm_sel=0`, `rf_we=1` and `psr_we=1` in cycle 3, then FETCH in cycle 4.
- `instr=0x53FF` (ADDI r3,-1). Expect `imm_sel=1`, `sign_ext=1`. With `instr=0x13FF` (ANDI), expect `sign_ext=0`.
- `instr=0xC0FE` (BEQ -2):
  - With `psr_flags=0x0040`: `pc_src=01`, `pc_en=1`.
  - With `psr_flags=0x0000`: `pc_src=00`.
- `instr=0x4201` (LOAD r2,[r1]) with `mem_ack` delayed 2 cycles in MEM:
  - MEM holds with `addr_sel=1`, `mem_we=0`.
  - WB asserts `rf_we=1`, `wb_sel=01`.
  - Total 7 cycles.
- `instr=0x4783` (JAL r7,r3):
  - With `CTRL_JUMP_EN`: `rf_we=1`, `wb_sel=10`, `pc_src=10`.
  - Without: `illegal=1` and no writes.
- `reset` low during MEM of STOR. Expect INIT on the same edge, all outputs 0, `mem_we` never asserted afterwards, and FETCH one cycle after release.
